rpn_sequencer: RTL
==================

Name: rpn_sequencer

Overview:
- Program sequencer for the W-bit RPN stack calculator (op codes 0..8: inc, dec, add, sub, mul, div, mod, push, pop; `apply`/`valid`/`head`/`empty` interface).
- Holds a small program memory loaded over a write port. On `start` it clears the calculator, issues each instruction with a single-cycle `apply`, and checks `valid` after every step.
- Reports the final top-of-stack, or an error code together with the failing program counter.

Parameters:
- W, 8, data width; must match the calculator.
- DEPTH, 16, program memory entries.
- AW, 4, address width; DEPTH <= 2^AW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- load_en  in  1  write enable for program memory.
- load_addr  in  AW  write address.
- load_op  in  4  op code to store.
- load_data  in  W  operand to store (used by op 7).
- prog_len  in  AW+1  instruction count, sampled on an accepted start.
- start  in  1  run request.
- calc_op  out  4  op code to the calculator.
- calc_in  out  W  operand to the calculator.
- calc_apply  out  1  apply strobe to the calculator.
- calc_clr  out  1  registered clear; ORed into the calculator's rst.
- calc_head  in  W  calculator head.
- calc_empty  in  1  calculator empty.
- calc_valid  in  1  calculator valid.
- busy  out  1  run in progress.
- done  out  1  run finished; level signal.
- error_code  out  2  0 ok, 1 calculator fault, 2 stack empty at end, 3 zero-length program.
- result  out  W  final head when error_code==0, else 0.
- pc  out  AW  current or failing instruction index.

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, error_code=0, result=0, pc=0, calc_clr=0, calc_apply=0. Program memory is not reset and keeps its contents. Reset mid-run aborts the run with no further apply.
- States: IDLE, CLEAR, ISSUE, CHECK, DONE. State register is a flop; calc_apply=1 exactly while in ISSUE; calc_clr is a flop that is high exactly during the CLEAR cycle.
- calc_op/calc_in = mem[pc] in every state; 0 in IDLE.
- Memory writes are accepted only in IDLE or DONE and are ignored while busy. A write and a start in the same cycle are both accepted; the write lands before the first ISSUE.
- IDLE/DONE + start:
  - prog_len==0 -> DONE with error_code=3, result=0, pc=0.
  - else latch prog_len, pc=0, done=0, error_code=0 -> CLEAR.
- busy=1 in CLEAR/ISSUE/CHECK. start while busy is ignored.
- CLEAR -> ISSUE after 1 cycle. The calculator sees async reset, giving size=0 and valid=1.
- ISSUE -> CHECK after 1 cycle. The calculator updates on the edge that leaves ISSUE.
- CHECK, judged on calc_valid:
  - calc_valid==0 -> DONE, error_code=1, pc held at the faulting index, result=0.
  - else if pc==len-1 -> DONE. If calc_empty: error_code=2, result=0. Else result=calc_head, error_code=0.
  - else pc+1 -> ISSUE.
- Throughput: 2 cycles per instruction. Total cycles from start to done=1 is 1 + 1 + 2*len.
- Arithmetic wraps modulo 2^W inside the calculator; the sequencer applies no width checks.
- pc never exceeds len-1. Memory addresses >= DEPTH alias modulo 2^AW; that case is illegal and unchecked.

Test Plan:
- Load {7:3, 7:4, 2, 7:5, 4}, len=5, start -> done after 12 cycles; result=35, error_code=0; calc_apply seen 5 times, calc_clr seen once.
- Load {7:6, 7:0, 5}, len=3 -> error_code=1, pc=2, result=0; no apply after the fault.
- Load {7:1, 8}, len=2 -> error_code=2, result=0. Then restart with len=1 -> result=1, error_code=0, showing the stack was cleared between runs.
- Load {7:200, 7:100, 2}, W=8 -> result=44 (wrap). Start with prog_len=0 -> done next cycle, error_code=3.
- start and load_en pulsed mid-run -> both ignored, program result unchanged. Assert rst mid-run -> busy=0 immediately; a rerun without reload gives the same result as before.

Source files
------------

// File: rtl/rpn_sequencer_if.sv
// Bundle of the host-side program/status signals and the calculator-side
// signals. The sequencer uses the slave view; whoever drives the program
// and plays the calculator uses the master view.
interface rpn_sequencer_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [3:0]    load_op;
  logic [W-1:0]  load_data;
  logic [AW:0]   prog_len;
  logic          start;

  logic [3:0]    calc_op;
  logic [W-1:0]  calc_in;
  logic          calc_apply;
  logic          calc_clr;
  logic [W-1:0]  calc_head;
  logic          calc_empty;
  logic          calc_valid;

  logic          busy;
  logic          done;
  logic [1:0]    error_code;
  logic [W-1:0]  result;
  logic [AW-1:0] pc;

  modport master (
    output load_en, load_addr, load_op, load_data, prog_len, start,
    output calc_head, calc_empty, calc_valid,
    input  calc_op, calc_in, calc_apply, calc_clr,
    input  busy, done, error_code, result, pc
  );

  modport slave (
    input  load_en, load_addr, load_op, load_data, prog_len, start,
    input  calc_head, calc_empty, calc_valid,
    output calc_op, calc_in, calc_apply, calc_clr,
    output busy, done, error_code, result, pc
  );
endinterface

// File: rtl/rpn_sequencer.sv
// Program sequencer for the RPN stack calculator. Stores a short program,
// clears the calculator, issues one instruction every two cycles and checks
// the calculator's valid flag after each one, then reports the final head or
// an error code with the offending instruction index.
module rpn_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic         clk,
  input logic         rst,
  rpn_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, CHECK, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    mem_op   [DEPTH];
  logic [W-1:0]  mem_data [DEPTH];
  logic [AW-1:0] pc, pc_next;
  logic [AW:0]   len, len_next;
  logic [1:0]    err, err_next;
  logic [W-1:0]  result, result_next;
  logic          calc_clr;
  logic          write_ok;
  logic          last;

  assign write_ok = bus.load_en && ((state == IDLE) || (state == DONE));
  assign last     = ({1'b0, pc} == (len - (AW+1)'(1)));

  // Program memory: written only while no run is in progress, never reset.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem_op[bus.load_addr]   <= bus.load_op;
      mem_data[bus.load_addr] <= bus.load_data;
    end
  end

  // Next-state and next-status logic for the run sequence.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    len_next    = len;
    err_next    = err;
    result_next = result;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.prog_len == '0) begin
            state_next  = DONE;
            err_next    = 2'd3;
            result_next = '0;
            pc_next     = '0;
          end else begin
            state_next = CLEAR;
            len_next   = bus.prog_len;
            pc_next    = '0;
            err_next   = 2'd0;
          end
        end
      end
      CLEAR: state_next = ISSUE;
      ISSUE: state_next = CHECK;
      CHECK: begin
        if (!bus.calc_valid) begin
          state_next  = DONE;
          err_next    = 2'd1;
          result_next = '0;
        end else if (last) begin
          state_next = DONE;
          if (bus.calc_empty) begin
            err_next    = 2'd2;
            result_next = '0;
          end else begin
            err_next    = 2'd0;
            result_next = bus.calc_head;
          end
        end else begin
          pc_next    = pc + AW'(1);
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and status registers; calc_clr is registered so it is glitch-free
  // when ORed into the calculator's asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      len      <= '0;
      err      <= 2'd0;
      result   <= '0;
      calc_clr <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      len      <= len_next;
      err      <= err_next;
      result   <= result_next;
      calc_clr <= (state_next == CLEAR);
    end
  end

  assign bus.calc_op    = (state == IDLE) ? 4'd0 : mem_op[pc];
  assign bus.calc_in    = (state == IDLE) ? '0   : mem_data[pc];
  assign bus.calc_apply = (state == ISSUE);
  assign bus.calc_clr   = calc_clr;
  assign bus.busy       = (state == CLEAR) || (state == ISSUE) || (state == CHECK);
  assign bus.done       = (state == DONE);
  assign bus.error_code = err;
  assign bus.result     = result;
  assign bus.pc         = pc;

endmodule
